// File: rtl/debug_step_ctrl_pkg.sv
// Shared definitions for the debug run/step/dump controller: command bytes,
// FSM state encoding and dump frame geometry.
package debug_step_ctrl_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;
  localparam logic [7:0] CMD_STOP = 8'h48;

  localparam int DUMP_WORDS = 5;
  localparam int DUMP_BYTES = 20;
  localparam int WORD_W     = 32;
  localparam int SNAP_W     = DUMP_WORDS * WORD_W;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_e;

endpackage

// File: rtl/debug_step_ctrl_dump_serializer.sv
// Captures the EX/MEM latch fields on i_start and streams them out as a
// 20-byte LSB-first frame over a valid/ready byte interface.
module dump_serializer
  import debug_step_ctrl_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_CTRL = 9,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_REG-1:0]  i_pc_eight,
  input  logic [NB_REG-1:0]  i_alu_result,
  input  logic [NB_REG-1:0]  i_w_data,
  input  logic [NB_ADDR-1:0] i_data_addr,
  input  logic [NB_CTRL-1:0] i_control_from_ex,
  input  logic               i_tx_ready,
  output logic               o_tx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_done
);

  logic [SNAP_W-1:0] snap_q, snap_d, snap_new;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;
  logic              xfer;

  function automatic logic [7:0] byte_sel(input logic [SNAP_W-1:0] s,
                                          input logic [CNT_W-1:0]  idx);
    return s[{idx, 3'b000} +: 8];
  endfunction

  // Word 0 sits in the low bits so byte index n maps directly to bits 8n+7:8n.
  assign snap_new = {WORD_W'(i_control_from_ex), WORD_W'(i_data_addr),
                     WORD_W'(i_w_data), WORD_W'(i_alu_result),
                     WORD_W'(i_pc_eight)};

  assign xfer = valid_q && i_tx_ready;

  always_comb begin
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    o_done  = 1'b0;
    if (i_start) begin
      snap_d  = snap_new;
      cnt_d   = '0;
      valid_d = 1'b1;
      data_d  = snap_new[7:0];
    end else if (xfer) begin
      if (cnt_q == CNT_W'(DUMP_BYTES - 1)) begin
        valid_d = 1'b0;
        cnt_d   = '0;
        o_done  = 1'b1;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        data_d = byte_sel(snap_q, cnt_d);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      snap_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_tx_valid = valid_q;
  assign o_tx_data  = data_q;

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug unit FSM: UART commands run, single-step, stop or dump the pipeline;
// a dump streams the EX/MEM latch snapshot through dump_serializer.
module debug_step_ctrl
  import debug_step_ctrl_pkg::*;
#(
  parameter int NB_REG  = 32,
  parameter int NB_CTRL = 9,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_valid,
  input  logic [7:0]         i_rx_data,
  input  logic               i_halt,
  input  logic [NB_REG-1:0]  i_pc_eight,
  input  logic [NB_REG-1:0]  i_alu_result,
  input  logic [NB_REG-1:0]  i_w_data,
  input  logic [NB_ADDR-1:0] i_data_addr,
  input  logic [NB_CTRL-1:0] i_control_from_ex,
  output logic               o_dunit_clk_en,
  output logic               o_tx_valid,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_ready,
  output logic               o_halted
);

  state_e state_q, state_d;
  logic   clk_en_q, clk_en_d;
  logic   halted_q, halted_d;
  logic   start_q, start_d;
  logic   ser_done;
  logic   cmd_run, cmd_step, cmd_dump, cmd_stop;

  assign cmd_run  = i_rx_valid && (i_rx_data == CMD_RUN);
  assign cmd_step = i_rx_valid && (i_rx_data == CMD_STEP);
  assign cmd_dump = i_rx_valid && (i_rx_data == CMD_DUMP);
  assign cmd_stop = i_rx_valid && (i_rx_data == CMD_STOP);

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q | i_halt;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_run && !halted_q)       state_d = ST_RUN;
        else if (cmd_step && !halted_q) state_d = ST_STEP;
        else if (cmd_dump)              state_d = ST_DUMP;
      end
      ST_RUN:  if (cmd_stop || i_halt) state_d = ST_IDLE;
      ST_STEP: state_d = ST_DUMP;
      ST_DUMP: if (ser_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Enable is registered from the next state so it rises the cycle after acceptance.
    clk_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    start_d  = (state_d == ST_DUMP) && (state_q != ST_DUMP);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      clk_en_q <= 1'b0;
      halted_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
      halted_q <= halted_d;
      start_q  <= start_d;
    end
  end

  // start_q is high during the first DUMP cycle, when the snapshot is taken.
  dump_serializer #(
    .NB_REG  (NB_REG),
    .NB_CTRL (NB_CTRL),
    .NB_ADDR (NB_ADDR)
  ) u_dump_serializer (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_start           (start_q),
    .i_pc_eight        (i_pc_eight),
    .i_alu_result      (i_alu_result),
    .i_w_data          (i_w_data),
    .i_data_addr       (i_data_addr),
    .i_control_from_ex (i_control_from_ex),
    .i_tx_ready        (i_tx_ready),
    .o_tx_valid        (o_tx_valid),
    .o_tx_data         (o_tx_data),
    .o_done            (ser_done)
  );

  assign o_dunit_clk_en = clk_en_q;
  assign o_halted       = halted_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed bench for debug_step_ctrl: step, run/halt, stalled dump, snapshot
// isolation, reset abort and ignored commands.
module tb_debug_step_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        halt;
  logic [31:0] pc_eight, alu_result, w_data;
  logic [4:0]  data_addr;
  logic [8:0]  ctrl;
  logic        clk_en, tx_valid, tx_ready, halted;
  logic [7:0]  tx_data;

  int n_tests = 0;
  int n_fail  = 0;
  int nx;
  logic [31:0] exp_w [5];

  always #5 clk = ~clk;

  debug_step_ctrl dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_rx_valid        (rx_valid),
    .i_rx_data         (rx_data),
    .i_halt            (halt),
    .i_pc_eight        (pc_eight),
    .i_alu_result      (alu_result),
    .i_w_data          (w_data),
    .i_data_addr       (data_addr),
    .i_control_from_ex (ctrl),
    .o_dunit_clk_en    (clk_en),
    .o_tx_valid        (tx_valid),
    .o_tx_data         (tx_data),
    .i_tx_ready        (tx_ready),
    .o_halted          (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic snap_expect();
    exp_w[0] = pc_eight;
    exp_w[1] = alu_result;
    exp_w[2] = w_data;
    exp_w[3] = {27'd0, data_addr};
    exp_w[4] = {23'd0, ctrl};
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = exp_w[i / 4];
    return w[8 * (i % 4) +: 8];
  endfunction

  // mode 1 drives ready 1-0-0-1 repeating; poke disturbs latches and sends 'C' mid-frame.
  task automatic collect(input int mode, input int stop_after, input bit poke, output int n);
    logic [3:0] pat;
    int cyc;
    int k;
    pat = 4'b1001;
    cyc = 0;
    k   = 0;
    n   = 0;
    while (n < stop_after && cyc < 400) begin
      if (tx_valid) begin
        check_eq($sformatf("byte%0d", n), {24'd0, tx_data}, {24'd0, exp_byte(n)});
        if (poke && n == 2) begin
          alu_result = 32'h0;
          rx_valid   = 1'b1;
          rx_data    = 8'h43;
        end
      end
      tx_ready = (mode == 1) ? pat[k % 4] : 1'b1;
      k++;
      if (tx_valid && tx_ready) n++;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      cyc++;
    end
    check_eq("collect_count", n, stop_after);
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0; tx_ready = 1'b0;
    pc_eight = 32'h0; alu_result = 32'h0; w_data = 32'h0; data_addr = 5'h0; ctrl = 9'h0;
    @(negedge clk);
    tick();
    tick();
    check_eq("rst_clk_en", clk_en, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_halted", halted, 0);
    rst = 1'b0;

    pc_eight = 32'h00000008; alu_result = 32'hDEADBEEF; w_data = 32'h12345678;
    data_addr = 5'h1F; ctrl = 9'h1A5;

    // Single step, capture timing, snapshot isolation, 'C' dropped during dump
    repeat (7) tick();
    snap_expect();
    send(8'h53);
    check_eq("step_en_on", clk_en, 1);
    tick();
    check_eq("step_en_off", clk_en, 0);
    check_eq("capture_no_valid", tx_valid, 0);
    tick();
    check_eq("valid_after_capture", tx_valid, 1);
    check_eq("first_byte_pc", tx_data, 8'h08);
    collect(0, 20, 1'b1, nx);
    check_eq("step_frame_end", tx_valid, 0);
    tick();
    check_eq("dump_c_dropped", clk_en, 0);
    alu_result = 32'hDEADBEEF;

    // Unknown byte and 'H' in IDLE
    send(8'h41);
    check_eq("unknown_no_en", clk_en, 0);
    tick();
    check_eq("unknown_no_valid", tx_valid, 0);
    send(8'h48);
    check_eq("idle_stop_no_en", clk_en, 0);

    // Dump with stalling receiver
    snap_expect();
    send(8'h44);
    collect(1, 20, 1'b0, nx);
    check_eq("stall_frame_end", tx_valid, 0);
    tick();
    check_eq("stall_idle_valid", tx_valid, 0);
    check_eq("stall_idle_en", clk_en, 0);

    // Run, then halt
    send(8'h43);
    check_eq("run_en_on", clk_en, 1);
    repeat (50) tick();
    check_eq("run_en_held", clk_en, 1);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("halt_en_off", clk_en, 0);
    check_eq("halt_sticky", halted, 1);
    send(8'h43);
    check_eq("halted_run_ignored", clk_en, 0);
    send(8'h53);
    check_eq("halted_step_ignored", clk_en, 0);
    tick();
    check_eq("halted_step_no_dump", tx_valid, 0);
    snap_expect();
    send(8'h44);
    collect(0, 20, 1'b0, nx);
    check_eq("halted_still", halted, 1);

    // Reset after byte 7 aborts the frame
    snap_expect();
    send(8'h44);
    collect(0, 8, 1'b0, nx);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_valid", tx_valid, 0);
    check_eq("abort_data", tx_data, 0);
    check_eq("abort_en", clk_en, 0);
    check_eq("abort_halted", halted, 0);
    tick();
    check_eq("abort_no_resume", tx_valid, 0);
    snap_expect();
    send(8'h44);
    collect(0, 20, 1'b0, nx);

    // Stop command and halt in the same RUN cycle
    send(8'h43);
    check_eq("run2_en_on", clk_en, 1);
    rx_valid = 1'b1; rx_data = 8'h48; halt = 1'b1;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00; halt = 1'b0;
    check_eq("both_en_off", clk_en, 0);
    check_eq("both_halted", halted, 1);
    tick();
    check_eq("both_idle_en", clk_en, 0);
    check_eq("both_idle_valid", tx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
